// File: rtl/sha_arbiter_if.sv
// rtl/sha_arbiter_if.sv - requester, SHA-core and status signals of the SHA arbiter
interface sha_arbiter_if;
    // requester 0 (key path)
    logic        req0_i;
    logic        rel0_i;
    logic        gnt0_o;
    logic        cs0_i;
    logic        we0_i;
    logic        wc0_i;
    logic [2:0]  addr0_i;
    logic [31:0] wdata0_i;
    logic        digest_valid0_o;

    // requester 1 (bitstream path)
    logic        req1_i;
    logic        rel1_i;
    logic        gnt1_o;
    logic        cs1_i;
    logic        we1_i;
    logic        wc1_i;
    logic [2:0]  addr1_i;
    logic [31:0] wdata1_i;
    logic        digest_valid1_o;

    // SHA core side
    logic        sha_reset_n_o;
    logic        sha_cs_o;
    logic        sha_we_o;
    logic        sha_wc_o;
    logic [2:0]  sha_address_o;
    logic [31:0] sha_write_data_o;
    logic        sha_digest_valid_i;

    // status
    logic        wdt_fault_o;

    modport master (
        output req0_i, rel0_i, cs0_i, we0_i, wc0_i, addr0_i, wdata0_i,
        output req1_i, rel1_i, cs1_i, we1_i, wc1_i, addr1_i, wdata1_i,
        output sha_digest_valid_i,
        input  gnt0_o, gnt1_o, digest_valid0_o, digest_valid1_o,
        input  sha_reset_n_o, sha_cs_o, sha_we_o, sha_wc_o,
        input  sha_address_o, sha_write_data_o, wdt_fault_o
    );

    modport slave (
        input  req0_i, rel0_i, cs0_i, we0_i, wc0_i, addr0_i, wdata0_i,
        input  req1_i, rel1_i, cs1_i, we1_i, wc1_i, addr1_i, wdata1_i,
        input  sha_digest_valid_i,
        output gnt0_o, gnt1_o, digest_valid0_o, digest_valid1_o,
        output sha_reset_n_o, sha_cs_o, sha_we_o, sha_wc_o,
        output sha_address_o, sha_write_data_o, wdt_fault_o
    );
endinterface

// File: rtl/sha_arbiter.sv
// rtl/sha_arbiter.sv - two-requester SHA core arbiter with scrub between owners; optional watchdog via SHA_ARB_WATCHDOG_EN
module sha_arbiter #(
    parameter int unsigned SCRUB_CYCLES = 2,
    parameter int unsigned WDT_CYCLES   = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    sha_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCRUB = 2'd1,
        OWN0  = 2'd2,
        OWN1  = 2'd3
    } state_t;

    localparam logic [3:0] SCRUB_LAST = 4'(SCRUB_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_gnt;
    logic       last_gnt_nxt;
    logic [3:0] scrub_cnt;
    logic       owner_rel;
    logic       wdt_revoke;

    // only the current owner's release pulse counts
    assign owner_rel = ((state == OWN0) && bus.rel0_i) ||
                       ((state == OWN1) && bus.rel1_i);

`ifdef SHA_ARB_WATCHDOG_EN
    localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);

    logic [15:0] wdt_cnt;
    logic        wdt_fault;
    logic        owner_idle;

    // owner is idle when none of its SHA strobes is active
    always_comb begin
        owner_idle = 1'b0;
        if (state == OWN0) begin
            owner_idle = !(bus.cs0_i || bus.we0_i || bus.wc0_i);
        end else if (state == OWN1) begin
            owner_idle = !(bus.cs1_i || bus.we1_i || bus.wc1_i);
        end
    end

    // the idle cycle that brings the count to WDT_CYCLES revokes, unless the owner releases anyway
    assign wdt_revoke = owner_idle && (wdt_cnt == WDT_LAST) && !owner_rel;

    // idle counter cleared by any strobe or state change; fault flag sticky until reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdt_cnt   <= 16'd0;
            wdt_fault <= 1'b0;
        end else begin
            if (!owner_idle || (state_nxt != state)) begin
                wdt_cnt <= 16'd0;
            end else begin
                wdt_cnt <= wdt_cnt + 16'd1;
            end
            if (wdt_revoke) begin
                wdt_fault <= 1'b1;
            end
        end
    end

    assign bus.wdt_fault_o = wdt_fault;
`else
    assign wdt_revoke      = 1'b0;
    assign bus.wdt_fault_o = 1'b0;
`endif

    // state, round-robin pointer and scrub counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            scrub_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            if ((state == SCRUB) && (state_nxt == SCRUB)) begin
                scrub_cnt <= scrub_cnt + 4'd1;
            end else begin
                scrub_cnt <= 4'd0;
            end
        end
    end

    // next-state: grant only from IDLE, so a release always passes through SCRUB
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (bus.req0_i && bus.req1_i) begin
                    if (last_gnt) begin
                        state_nxt    = OWN0;
                        last_gnt_nxt = 1'b0;
                    end else begin
                        state_nxt    = OWN1;
                        last_gnt_nxt = 1'b1;
                    end
                end else if (bus.req0_i) begin
                    state_nxt    = OWN0;
                    last_gnt_nxt = 1'b0;
                end else if (bus.req1_i) begin
                    state_nxt    = OWN1;
                    last_gnt_nxt = 1'b1;
                end
            end
            SCRUB: begin
                if (scrub_cnt == SCRUB_LAST) begin
                    state_nxt = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (owner_rel || wdt_revoke) begin
                    state_nxt = SCRUB;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // output routing: owner's strobes mirrored combinationally, everything quiet otherwise
    always_comb begin
        bus.gnt0_o           = 1'b0;
        bus.gnt1_o           = 1'b0;
        bus.digest_valid0_o  = 1'b0;
        bus.digest_valid1_o  = 1'b0;
        bus.sha_cs_o         = 1'b0;
        bus.sha_we_o         = 1'b0;
        bus.sha_wc_o         = 1'b0;
        bus.sha_address_o    = 3'd0;
        bus.sha_write_data_o = 32'd0;
        case (state)
            OWN0: begin
                bus.gnt0_o           = 1'b1;
                bus.digest_valid0_o  = bus.sha_digest_valid_i;
                bus.sha_cs_o         = bus.cs0_i;
                bus.sha_we_o         = bus.we0_i;
                bus.sha_wc_o         = bus.wc0_i;
                bus.sha_address_o    = bus.addr0_i;
                bus.sha_write_data_o = bus.wdata0_i;
            end
            OWN1: begin
                bus.gnt1_o           = 1'b1;
                bus.digest_valid1_o  = bus.sha_digest_valid_i;
                bus.sha_cs_o         = bus.cs1_i;
                bus.sha_we_o         = bus.we1_i;
                bus.sha_wc_o         = bus.wc1_i;
                bus.sha_address_o    = bus.addr1_i;
                bus.sha_write_data_o = bus.wdata1_i;
            end
            default: ;
        endcase
    end

    // core held in reset during SCRUB and while the arbiter itself is in reset
    assign bus.sha_reset_n_o = reset_n && (state != SCRUB);

endmodule

// File: tb/tb_sha_arbiter.sv
// tb/tb_sha_arbiter.sv - scoreboard testbench for sha_arbiter
module tb_sha_arbiter;

`ifdef SHA_ARB_WATCHDOG_EN
    localparam int WDT = 8;
`else
    localparam int WDT = 1024;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    sha_arbiter_if bus ();

    sha_arbiter #(
        .SCRUB_CYCLES (2),
        .WDT_CYCLES   (WDT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q[$];
    logic gnt0_q   = 1'b0;
    logic gnt1_q   = 1'b0;
    int   exp_owner;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_i = 0; bus.rel0_i = 0; bus.cs0_i = 0; bus.we0_i = 0; bus.wc0_i = 0;
        bus.addr0_i = 0; bus.wdata0_i = 0;
        bus.req1_i = 0; bus.rel1_i = 0; bus.cs1_i = 0; bus.we1_i = 0; bus.wc1_i = 0;
        bus.addr1_i = 0; bus.wdata1_i = 0;
        bus.sha_digest_valid_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        tick();
        reset_n = 1;
    endtask

    // release the current owner while the other request is pending; expect SCRUB then the next grant
    task automatic release_and_regrant(input int owner, input int next);
        if (owner == 0) bus.rel0_i = 1; else bus.rel1_i = 1;
        exp_q.push_back(next);
        tick();
        bus.rel0_i = 0;
        bus.rel1_i = 0;
        check("rel_gnt_drop", {31'd0, bus.gnt0_o | bus.gnt1_o}, 0);
        check("scrub1_rstn", {31'd0, bus.sha_reset_n_o}, 0);
        check("scrub1_cs", {31'd0, bus.sha_cs_o}, 0);
        tick();
        check("scrub2_rstn", {31'd0, bus.sha_reset_n_o}, 0);
        check("scrub2_no_gnt", {31'd0, bus.gnt0_o | bus.gnt1_o}, 0);
        tick();
        check("idle_rstn", {31'd0, bus.sha_reset_n_o}, 1);
        check("idle_no_gnt", {31'd0, bus.gnt0_o | bus.gnt1_o}, 0);
        tick();
        check("regrant", {31'd0, (next == 0) ? bus.gnt0_o : bus.gnt1_o}, 1);
    endtask

    // scoreboard: every grant rising edge must match the next expected owner
    always @(negedge clk) begin
        if ((bus.gnt0_o && !gnt0_q) || (bus.gnt1_o && !gnt1_q)) begin
            check("gnt_onehot", {31'd0, bus.gnt0_o & bus.gnt1_o}, 0);
            if (exp_q.size() == 0) begin
                check("gnt_unexpected", exp_q.size(), 1);
            end else begin
                exp_owner = exp_q.pop_front();
                check("gnt_owner", bus.gnt1_o ? 32'd1 : 32'd0, exp_owner);
            end
        end
        gnt0_q <= bus.gnt0_o;
        gnt1_q <= bus.gnt1_o;
    end

    initial begin
        int drops;
        clear_inputs();
        bus.sha_digest_valid_i = 1;
        reset_n = 0;
        tick();
        tick();
        check("rst_gnt0", {31'd0, bus.gnt0_o}, 0);
        check("rst_gnt1", {31'd0, bus.gnt1_o}, 0);
        check("rst_wdt", {31'd0, bus.wdt_fault_o}, 0);
        check("rst_sha_rstn", {31'd0, bus.sha_reset_n_o}, 0);
        check("rst_cs", {31'd0, bus.sha_cs_o}, 0);
        check("rst_addr", {29'd0, bus.sha_address_o}, 0);
        check("rst_data", bus.sha_write_data_o, 0);
        check("rst_dv", {30'd0, bus.digest_valid1_o, bus.digest_valid0_o}, 0);
        bus.sha_digest_valid_i = 0;
        reset_n = 1;
        tick();
        check("run_sha_rstn", {31'd0, bus.sha_reset_n_o}, 1);

        // single request, grant latency and mirroring
        bus.req0_i = 1; bus.cs0_i = 1; bus.addr0_i = 3; bus.wdata0_i = 32'hDEADBEEF;
        exp_q.push_back(0);
        #1;
        check("gnt0_before_edge", {31'd0, bus.gnt0_o}, 0);
        tick();
        check("gnt0_granted", {31'd0, bus.gnt0_o}, 1);
        check("mirror_cs", {31'd0, bus.sha_cs_o}, 1);
        check("mirror_addr", {29'd0, bus.sha_address_o}, 3);
        check("mirror_data", bus.sha_write_data_o, 32'hDEADBEEF);
        bus.req0_i = 0;
        tick();
        check("gnt_held_req_low", {31'd0, bus.gnt0_o}, 1);
        bus.rel1_i = 1;
        tick();
        bus.rel1_i = 0;
        check("nonowner_rel_gnt0", {31'd0, bus.gnt0_o}, 1);
        check("nonowner_rel_rstn", {31'd0, bus.sha_reset_n_o}, 1);
        bus.rel0_i = 1;
        tick();
        bus.rel0_i = 0;
        check("rel0_drop", {31'd0, bus.gnt0_o}, 0);
        check("rel0_scrub_cs", {31'd0, bus.sha_cs_o}, 0);
        check("rel0_scrub_data", bus.sha_write_data_o, 0);
        tick();
        tick();
        check("rel0_idle_rstn", {31'd0, bus.sha_reset_n_o}, 1);

        // dual request alternation 0,1,0 then 1
        do_reset();
        bus.req0_i = 1; bus.req1_i = 1;
        exp_q.push_back(0);
        tick();
        check("dual_first_gnt0", {31'd0, bus.gnt0_o}, 1);
        release_and_regrant(0, 1);
        release_and_regrant(1, 0);
        release_and_regrant(0, 1);

        // owner 1 routing and isolation of requester 0
        bus.req0_i = 0; bus.req1_i = 0;
        bus.sha_digest_valid_i = 1;
        bus.cs0_i = 1; bus.addr0_i = 2; bus.wdata0_i = 32'h12345678;
        bus.cs1_i = 1; bus.we1_i = 1; bus.addr1_i = 5; bus.wdata1_i = 32'hCAFEF00D;
        #1;
        check("own1_data", bus.sha_write_data_o, 32'hCAFEF00D);
        check("own1_addr", {29'd0, bus.sha_address_o}, 5);
        check("own1_we", {31'd0, bus.sha_we_o}, 1);
        check("own1_dv1", {31'd0, bus.digest_valid1_o}, 1);
        check("own1_dv0", {31'd0, bus.digest_valid0_o}, 0);
        for (int i = 0; i < 8; i++) begin
            bus.wdata0_i = $urandom;
            bus.wdata1_i = $urandom;
            bus.cs1_i    = 1'($urandom_range(0, 1));
            bus.addr1_i  = 3'($urandom_range(0, 7));
            tick();
            check("own1_rand_data", bus.sha_write_data_o, bus.wdata1_i);
            check("own1_rand_addr", {29'd0, bus.sha_address_o}, {29'd0, bus.addr1_i});
            check("own1_rand_cs", {31'd0, bus.sha_cs_o}, {31'd0, bus.cs1_i});
        end
        bus.sha_digest_valid_i = 0;
        bus.cs0_i = 0; bus.cs1_i = 0; bus.we1_i = 0; bus.wc1_i = 0;
        bus.wdata0_i = 0; bus.wdata1_i = 0;

        // idle owner: watchdog revoke or indefinite hold
`ifdef SHA_ARB_WATCHDOG_EN
        repeat (WDT - 1) tick();
        check("wdt_before_limit", {31'd0, bus.gnt1_o}, 1);
        tick();
        check("wdt_revoked", {31'd0, bus.gnt1_o}, 0);
        check("wdt_scrub", {31'd0, bus.sha_reset_n_o}, 0);
        check("wdt_fault_set", {31'd0, bus.wdt_fault_o}, 1);
        repeat (20) tick();
        check("wdt_fault_sticky", {31'd0, bus.wdt_fault_o}, 1);
        do_reset();
        check("wdt_fault_cleared", {31'd0, bus.wdt_fault_o}, 0);
`else
        drops = 0;
        repeat (2000) begin
            tick();
            if (!bus.gnt1_o) drops++;
        end
        check("hold_2000_drops", drops, 0);
        check("no_wdt_fault", {31'd0, bus.wdt_fault_o}, 0);
        do_reset();
`endif

        // reset in the first SCRUB cycle aborts the scrub
        bus.req0_i = 1;
        exp_q.push_back(0);
        tick();
        check("pre_abort_gnt0", {31'd0, bus.gnt0_o}, 1);
        bus.req0_i = 0;
        bus.rel0_i = 1;
        tick();
        bus.rel0_i = 0;
        check("abort_scrub1", {31'd0, bus.sha_reset_n_o}, 0);
        reset_n = 0;
        bus.sha_digest_valid_i = 1;
        tick();
        check("abort_gnt", {31'd0, bus.gnt0_o | bus.gnt1_o}, 0);
        check("abort_rstn_low", {31'd0, bus.sha_reset_n_o}, 0);
        check("abort_dv", {30'd0, bus.digest_valid1_o, bus.digest_valid0_o}, 0);
        check("abort_wdt", {31'd0, bus.wdt_fault_o}, 0);
        reset_n = 1;
        bus.sha_digest_valid_i = 0;
        tick();
        check("abort_no_resume", {31'd0, bus.sha_reset_n_o}, 1);
        bus.req1_i = 1;
        exp_q.push_back(1);
        tick();
        check("abort_idle_gnt1", {31'd0, bus.gnt1_o}, 1);
        bus.req1_i = 0;

        #10;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha_arbiter.md
SHA_ARBITER -- requirements
Module: sha_arbiter

Interface
REQ-001 Parameter SCRUB_CYCLES, default 2: cycles sha_reset_n_o is held low between owners (range 1-15).
REQ-002 Parameter WDT_CYCLES, default 1024: watchdog limit in idle-bus cycles (range 2-65535).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 req0_i, req1_i  input  1 each  request for the SHA core (0 = key path, 1 = bitstream path).
REQ-006 rel0_i, rel1_i  input  1 each  single-cycle release pulse from the current owner.
REQ-007 gnt0_o, gnt1_o  output  1 each  grant; at most one high.
REQ-008 csN_i, weN_i, wcN_i  input  1 each  per-requester SHA strobes, N = 0,1.
REQ-009 addrN_i  input  3; wdataN_i  input  32  per-requester SHA address and write data.
REQ-010 sha_reset_n_o, sha_cs_o, sha_we_o, sha_wc_o  output  1 each  to the SHA core.
REQ-011 sha_address_o  output  3; sha_write_data_o  output  32  to the SHA core.
REQ-012 sha_digest_valid_i  input  1  from the SHA core.
REQ-013 digest_valid0_o, digest_valid1_o  output  1 each  routed digest_valid.
REQ-014 wdt_fault_o  output  1  sticky watchdog-revoke flag (see Configuration).

Function
REQ-015 FSM states: IDLE, SCRUB, OWN0, OWN1.
REQ-016 IDLE: pending request -> registered grant; gntN_o rises one cycle after reqN_i is sampled high; state -> OWNN.
REQ-017 Both requests in IDLE in the same cycle: the requester not granted last wins; after reset, requester 0 wins.
REQ-018 OWNN: the SHA outputs SHALL combinationally mirror csN_i/weN_i/wcN_i/addrN_i/wdataN_i; the non-owner's inputs are ignored.
REQ-019 Not owning (IDLE, SCRUB): sha_cs_o, sha_we_o, sha_wc_o = 0; sha_address_o = 0; sha_write_data_o = 0.
REQ-020 digest_validN_o = sha_digest_valid_i AND state==OWNN; otherwise 0.
REQ-021 relN_i in OWNN: gntN_o drops next cycle; state -> SCRUB.
REQ-022 relN_i from a non-owner: ignored.
REQ-023 reqN_i falling without relN_i: grant held.
REQ-024 SCRUB: sha_reset_n_o low for exactly SCRUB_CYCLES cycles; then -> IDLE.
REQ-025 SCRUB clears hash state between owners; requests are not granted during SCRUB.
REQ-026 Outside SCRUB and reset: sha_reset_n_o = 1.
REQ-027 Minimum owner-to-owner handover: release cycle + SCRUB_CYCLES + 1 grant cycle.
REQ-028 Release and the other requester's request in the same cycle: the other requester is granted after SCRUB; it is never granted directly.

Reset
REQ-029 reset_n low at a clock edge: state -> IDLE; last-granted pointer -> 1 (so requester 0 has priority); scrub and watchdog counters -> 0.
REQ-030 Output reset values: gnt0_o = gnt1_o = 0, wdt_fault_o = 0, digest_validN_o = 0, all SHA strobes/address/data = 0.
REQ-031 sha_reset_n_o SHALL be 0 while reset_n is low.
REQ-032 Reset mid-ownership or mid-SCRUB aborts immediately; SCRUB does not resume.

Configuration
REQ-033 Macro SHA_ARB_WATCHDOG_EN defined: in OWNN, count consecutive cycles with csN_i = weN_i = wcN_i = 0.
REQ-034 Any owner strobe, or a state change, clears the count.
REQ-035 Count reaching WDT_CYCLES: revoke the grant as an implicit release (-> SCRUB) and set wdt_fault_o.
REQ-036 wdt_fault_o clears only on reset.
REQ-037 Macro not defined: no counter; grants last until relN_i; wdt_fault_o tied to 0.

Verification
REQ-038 Reset, then req0_i = 1 -> gnt0_o = 1 one cycle later; cs0_i/addr0_i = 3/wdata0_i = 0xDEADBEEF appear on SHA outputs the same cycle.
REQ-039 req0_i and req1_i rise together after reset -> gnt0_o; rel0_i -> sha_reset_n_o low 2 cycles, then gnt1_o; repeated dual request -> alternates 0,1,0.
REQ-040 Owner 1 active, sha_digest_valid_i = 1 -> digest_valid1_o = 1, digest_valid0_o = 0; wdata0_i = 0x12345678 never reaches sha_write_data_o.
REQ-041 rel1_i pulsed while requester 0 owns -> no state change; gnt0_o stays 1.
REQ-042 With SHA_ARB_WATCHDOG_EN and WDT_CYCLES = 8: owner idle 8 cycles -> gnt dropped, SCRUB entered, wdt_fault_o = 1 until reset; without the macro, grant held 2000 idle cycles.
REQ-043 reset_n low during SCRUB cycle 1 -> all outputs at reset values next edge; state IDLE after reset_n returns high.
